// File: rtl/irq_pending_capture.sv
// Pending-request capture around an external 8-input priority-to-one-hot stage; grant is encoded and handed off over valid/ready.
// Define IRQ_EDGE_DETECT_EN for rising-edge request capture; the default build captures request levels.
module irq_pending_capture #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] req_i,
    input  logic [WIDTH-1:0] mask_i,
    output logic [WIDTH-1:0] pend_o,
    input  logic [WIDTH-1:0] grant_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             grant_err_o,
    output logic [CNT_W-1:0] lost_cnt_o
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] req_q;
    logic [WIDTH-1:0] set_vec;
    logic [WIDTH-1:0] clr_vec;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] idx_next;
    logic             valid_next;
    logic             err_next;
    logic             lost_hit;

`ifdef IRQ_EDGE_DETECT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q <= '0;
        end else begin
            req_q <= req_i;
        end
    end
`else
    // Level capture keeps no request history; a zero req_q makes set_vec the raw lines.
    assign req_q = '0;
`endif

    assign set_vec  = req_i & ~req_q;
    assign clr_vec  = (state == HOLD && ready_i) ? (WIDTH'(1) << idx_o) : '0;
    assign lost_hit = |(set_vec & pending & ~clr_vec);
    assign pend_o   = pending & ~mask_i;

    // Set is OR-ed in after the clear so a same-cycle set keeps the bit pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending    <= '0;
            lost_cnt_o <= '0;
        end else begin
            pending <= (pending & ~clr_vec) | set_vec;
            if (lost_hit && lost_cnt_o != '1) begin
                lost_cnt_o <= lost_cnt_o + CNT_W'(1);
            end
        end
    end

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (grant_i[i]) begin
                grant_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = idx_o;
        valid_next = valid_o;
        err_next   = 1'b0;
        case (state)
            IDLE: begin
                valid_next = 1'b0;
                if (grant_i != '0) begin
                    idx_next   = grant_idx;
                    valid_next = 1'b1;
                    err_next   = (grant_i & (grant_i - WIDTH'(1))) != '0;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (ready_i) begin
                    valid_next = 1'b0;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            idx_o       <= '0;
            valid_o     <= 1'b0;
            grant_err_o <= 1'b0;
        end else begin
            state       <= state_next;
            idx_o       <= idx_next;
            valid_o     <= valid_next;
            grant_err_o <= err_next;
        end
    end

endmodule
